// File: rtl/mem_store_unit.sv
// rtl/mem_store_unit.sv - store unit: lane steering, byte enables and memory write handshake with timeout (optional MISALIGN_EXC_EN)
module mem_store_unit #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  wait_cnt;

  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic        illegal_nxt;

  // Steer the request onto byte lanes and decide whether it may be issued
  always_comb begin
    be_nxt      = 4'b0000;
    wdata_nxt   = st_data;
    illegal_nxt = 1'b0;
    case (st_size)
      2'b00: begin
        be_nxt    = 4'b0001 << st_addr[1:0];
        wdata_nxt = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = st_addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{st_data[15:0]}};
`ifdef MISALIGN_EXC_EN
        illegal_nxt = st_addr[0];
`else
        illegal_nxt = 1'b0;
`endif
      end
      2'b10: begin
        be_nxt    = 4'b1111;
        wdata_nxt = st_data;
`ifdef MISALIGN_EXC_EN
        illegal_nxt = |st_addr[1:0];
`else
        illegal_nxt = 1'b0;
`endif
      end
      default: begin
        be_nxt      = 4'b0000;
        wdata_nxt   = st_data;
        illegal_nxt = 1'b1;
      end
    endcase
  end

  // Handshake FSM; every output is registered so the control unit sees clean pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_req) begin
            mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= wdata_nxt;
            mem_be    <= be_nxt;
            wait_cnt  <= 8'd0;
            st_busy   <= 1'b1;
            if (illegal_nxt) begin
              state  <= S_ERR;
              st_err <= 1'b1;
              mem_we <= 1'b0;
            end else begin
              state  <= S_WAIT;
              mem_we <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // An ack in the final allowed cycle still completes the store
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_we  <= 1'b0;
            st_busy <= 1'b0;
            st_done <= 1'b1;
          end else if (wait_cnt == 8'(WAIT_MAX)) begin
            state   <= S_IDLE;
            mem_we  <= 1'b0;
            st_busy <= 1'b0;
            st_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_ERR: begin
          state   <= S_IDLE;
          st_busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          mem_we  <= 1'b0;
          st_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// tb/tb_mem_store_unit.sv - directed table-driven bench for mem_store_unit
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.ADDR_W(32), .WAIT_MAX(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_req    (st_req),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_dly;
    int          exp_we;
    logic        exp_done;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    st_req  = 1'b0;
    st_size = 2'b00;
    st_addr = 32'd0;
    st_data = 32'd0;
    mem_ack = 1'b0;
  endtask

  initial begin
    // size, addr, data, ack_dly, we cycles, done, err, latency, addr, be, wdata
    vecs[0] = '{2'b10, 32'h100, 32'hDEADBEEF, 2,   3,  1'b1, 1'b0, 4,  32'h100, 4'b1111, 32'hDEADBEEF};
    vecs[1] = '{2'b00, 32'h103, 32'h000000A5, 0,   1,  1'b1, 1'b0, 2,  32'h100, 4'b1000, 32'hA5A5A5A5};
    vecs[2] = '{2'b01, 32'h202, 32'h00001234, 1,   2,  1'b1, 1'b0, 3,  32'h200, 4'b1100, 32'h12341234};
    vecs[3] = '{2'b01, 32'h200, 32'hFFFFABCD, 0,   1,  1'b1, 1'b0, 2,  32'h200, 4'b0011, 32'hABCDABCD};
    vecs[4] = '{2'b00, 32'h101, 32'h1234567E, 3,   4,  1'b1, 1'b0, 5,  32'h100, 4'b0010, 32'h7E7E7E7E};
`ifdef MISALIGN_EXC_EN
    vecs[5] = '{2'b10, 32'h101, 32'hCAFEF00D, 0,   0,  1'b0, 1'b1, 1,  32'h0,   4'b0000, 32'h0};
    vecs[9] = '{2'b01, 32'h203, 32'h00005678, 0,   0,  1'b0, 1'b1, 1,  32'h0,   4'b0000, 32'h0};
`else
    vecs[5] = '{2'b10, 32'h101, 32'hCAFEF00D, 0,   1,  1'b1, 1'b0, 2,  32'h100, 4'b1111, 32'hCAFEF00D};
    vecs[9] = '{2'b01, 32'h203, 32'h00005678, 0,   1,  1'b1, 1'b0, 2,  32'h200, 4'b1100, 32'h56785678};
`endif
    vecs[6] = '{2'b11, 32'h300, 32'h11223344, 0,   0,  1'b0, 1'b1, 1,  32'h0,   4'b0000, 32'h0};
    vecs[7] = '{2'b10, 32'h400, 32'h11112222, 255, 16, 1'b0, 1'b1, 17, 32'h400, 4'b1111, 32'h11112222};
    vecs[8] = '{2'b10, 32'h404, 32'h33334444, 15,  16, 1'b1, 1'b0, 17, 32'h404, 4'b1111, 32'h33334444};

    rst = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {st_busy, st_done, st_err, mem_we, mem_be, mem_addr, mem_wdata}, 128'd0);
    rst = 1'b1;

    for (int v = 0; v < NV; v++) begin
      int          we_cnt;
      int          lat;
      logic        got_done;
      logic        got_err;
      logic [31:0] cap_addr;
      logic [31:0] cap_wdata;
      logic [3:0]  cap_be;
      we_cnt    = 0;
      lat       = -1;
      got_done  = 1'b0;
      got_err   = 1'b0;
      cap_addr  = 32'd0;
      cap_wdata = 32'd0;
      cap_be    = 4'd0;
      @(negedge clk);
      st_req  = 1'b1;
      st_size = vecs[v].size;
      st_addr = vecs[v].addr;
      st_data = vecs[v].data;
      mem_ack = 1'b0;
      @(negedge clk);
      st_req = 1'b0;
      chk($sformatf("v%0d_busy", v), st_busy, 1'b1);
      for (int c = 1; c <= 40; c++) begin
        if (c > 1) @(negedge clk);
        if (mem_we) begin
          if (we_cnt == 0) begin
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            cap_be    = mem_be;
          end
          we_cnt++;
        end
        mem_ack = mem_we && (we_cnt - 1 == vecs[v].ack_dly);
        if (st_done || st_err) begin
          got_done = st_done;
          got_err  = st_err;
          lat      = c;
          break;
        end
      end
      mem_ack = 1'b0;
      chk($sformatf("v%0d_we_cycles", v), we_cnt, vecs[v].exp_we);
      chk($sformatf("v%0d_done", v), got_done, vecs[v].exp_done);
      chk($sformatf("v%0d_err", v), got_err, vecs[v].exp_err);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      if (vecs[v].exp_we > 0) begin
        chk($sformatf("v%0d_addr", v), cap_addr, vecs[v].exp_addr);
        chk($sformatf("v%0d_be", v), cap_be, vecs[v].exp_be);
        chk($sformatf("v%0d_wdata", v), cap_wdata, vecs[v].exp_wdata);
      end
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", v), {st_done, st_err, mem_we, st_busy}, 4'b0000);
    end

    // Back-to-back: second store requested in the st_done cycle of the first
    @(negedge clk);
    st_req = 1'b1; st_size = 2'b01; st_addr = 32'h202; st_data = 32'h00001234;
    @(negedge clk);
    st_req = 1'b0;
    chk("b2b_first_we", {mem_we, mem_be, mem_wdata}, {1'b1, 4'b1100, 32'h12341234});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_first_done", {st_done, st_err, mem_we}, 3'b100);
    st_req = 1'b1; st_size = 2'b10; st_addr = 32'h500; st_data = 32'h89ABCDEF;
    @(negedge clk);
    st_req = 1'b0;
    chk("b2b_second_we", {mem_we, st_busy, mem_addr, mem_be, mem_wdata},
        {1'b1, 1'b1, 32'h500, 4'b1111, 32'h89ABCDEF});
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b_second_done", {st_done, st_err, mem_we}, 3'b100);

    // Request while busy is ignored and produces no second write
    @(negedge clk);
    st_req = 1'b1; st_size = 2'b10; st_addr = 32'h700; st_data = 32'h00000001;
    @(negedge clk);
    st_addr = 32'h800; st_data = 32'h00000002;
    chk("busy_first_we", {mem_we, mem_addr}, {1'b1, 32'h700});
    @(negedge clk);
    @(negedge clk);
    chk("busy_held_payload", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h700, 32'h00000001});
    st_req = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("busy_done", {st_done, mem_we}, 2'b10);
    @(negedge clk);
    chk("busy_no_second_write", {mem_we, st_busy, st_done}, 3'b000);

    // Reset in the middle of WAIT aborts silently
    st_req = 1'b1; st_size = 2'b10; st_addr = 32'h600; st_data = 32'h5A5A5A5A;
    @(negedge clk);
    st_req = 1'b0;
    chk("rstwait_we", mem_we, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstwait_outputs", {st_busy, st_done, st_err, mem_we, mem_be, mem_addr, mem_wdata}, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_after", {st_busy, st_done, st_err, mem_we}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
